// File: rtl/lcd_scan.sv
// VGA 640x480 scan-out of the 640x64 Z88 bitmap held in VRAM, line-quadrupled
// into a vertically centred 640x256 window with a border colour around it.
module lcd_scan #(
   parameter int          H_ACTIVE     = 640,
   parameter int          H_TOTAL      = 800,
   parameter int          H_SYNC_START = 656,
   parameter int          H_SYNC_END   = 752,
   parameter int          V_ACTIVE     = 480,
   parameter int          V_TOTAL      = 525,
   parameter int          V_SYNC_START = 490,
   parameter int          V_SYNC_END   = 492,
   parameter int          Y_START      = 112,
   parameter logic [11:0] COL_ON       = 12'h114,
   parameter logic [11:0] COL_OFF      = 12'hBCA,
   parameter logic [11:0] COL_BORDER   = 12'h333
) (
   input  logic        mck,
   input  logic        rin,
   input  logic        pix_ce,
   output logic [13:0] vram_ra,
   output logic        vram_re,
   input  logic [3:0]  vram_di,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [11:0] rgb,
   output logic        frame_start
);

   localparam logic [9:0] HA   = 10'(H_ACTIVE);
   localparam logic [9:0] HA4  = 10'(H_ACTIVE - 4);
   localparam logic [9:0] HT1  = 10'(H_TOTAL - 1);
   localparam logic [9:0] HT3  = 10'(H_TOTAL - 3);
   localparam logic [9:0] HSS  = 10'(H_SYNC_START);
   localparam logic [9:0] HSE  = 10'(H_SYNC_END);
   localparam logic [9:0] VA   = 10'(V_ACTIVE);
   localparam logic [9:0] VT1  = 10'(V_TOTAL - 1);
   localparam logic [9:0] VSS  = 10'(V_SYNC_START);
   localparam logic [9:0] VSE  = 10'(V_SYNC_END);
   localparam logic [9:0] Y0   = 10'(Y_START);
   localparam logic [9:0] YEND = 10'(Y_START + 256);

   logic [9:0]  r_hcnt;
   logic [9:0]  r_vcnt;
   logic [3:0]  r_shift;
   logic        r_rd_pend;
   logic [13:0] r_ra;
   logic        r_re;
   logic        r_hsync;
   logic        r_vsync;
   logic        r_de;
   logic [11:0] r_rgb;
   logic        r_fs;

   logic        w_h_last;
   logic        w_v_last;
   logic [9:0]  w_nv;
   logic        w_cur_win;
   logic        w_nxt_win;
   logic [5:0]  w_cur_row;
   logic [5:0]  w_nxt_row;
   logic        w_pf_slot;
   logic        w_pf_cur;
   logic        w_pf_nxt;
   logic [13:0] w_pf_addr;
   logic        w_pix_bit;
   logic        w_de;
   logic [11:0] w_rgb;

   always_comb begin
      w_h_last  = (r_hcnt == HT1);
      w_v_last  = (r_vcnt == VT1);
      w_nv      = w_v_last ? 10'd0 : r_vcnt + 10'd1;
      w_cur_win = (r_vcnt >= Y0) && (r_vcnt < YEND);
      w_nxt_win = (w_nv >= Y0) && (w_nv < YEND);
      w_cur_row = 6'((r_vcnt - Y0) >> 2);
      w_nxt_row = 6'((w_nv - Y0) >> 2);
      // The slot at hcnt[1:0]=01 fetches the nibble shown from the next 4-pixel
      // group on; the hcnt=H_TOTAL-3 slot primes nibble 0 of the following line.
      w_pf_slot = (r_hcnt[1:0] == 2'b01);
      w_pf_cur  = w_pf_slot && (r_hcnt < HA4) && w_cur_win;
      w_pf_nxt  = w_pf_slot && (r_hcnt == HT3) && w_nxt_win;
      w_pf_addr = w_pf_cur ? {w_cur_row, r_hcnt[9:2] + 8'd1} : {w_nxt_row, 8'd0};
      w_pix_bit = r_shift[~r_hcnt[1:0]];
      w_de      = (r_hcnt < HA) && (r_vcnt < VA);
      w_rgb     = 12'd0;
      if (w_de) begin
         if (!w_cur_win)     w_rgb = COL_BORDER;
         else if (w_pix_bit) w_rgb = COL_ON;
         else                w_rgb = COL_OFF;
      end
   end

   always_ff @(posedge mck) begin
      if (rin) begin
         r_hcnt    <= 10'd0;
         r_vcnt    <= 10'd0;
         r_shift   <= 4'd0;
         r_rd_pend <= 1'b0;
         r_ra      <= 14'd0;
         r_re      <= 1'b0;
         r_hsync   <= 1'b1;
         r_vsync   <= 1'b1;
         r_de      <= 1'b0;
         r_rgb     <= 12'd0;
         r_fs      <= 1'b0;
      end else begin
         r_fs <= 1'b0;
         if (pix_ce) begin
            r_hcnt <= w_h_last ? 10'd0 : r_hcnt + 10'd1;
            if (w_h_last) r_vcnt <= w_v_last ? 10'd0 : r_vcnt + 10'd1;

            if (w_pf_slot) begin
               r_re      <= w_pf_cur || w_pf_nxt;
               r_rd_pend <= w_pf_cur || w_pf_nxt;
               if (w_pf_cur || w_pf_nxt) r_ra <= w_pf_addr;
            end else begin
               r_re <= 1'b0;
            end

            if (r_hcnt[1:0] == 2'b11) r_shift <= r_rd_pend ? vram_di : 4'd0;

            r_hsync <= !((r_hcnt >= HSS) && (r_hcnt < HSE));
            r_vsync <= !((r_vcnt >= VSS) && (r_vcnt < VSE));
            r_de    <= w_de;
            r_rgb   <= w_rgb;
            r_fs    <= (r_hcnt == 10'd0) && (r_vcnt == 10'd0);
         end
      end
   end

   assign vram_ra     = r_ra;
   assign vram_re     = r_re;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign de          = r_de;
   assign rgb         = r_rgb;
   assign frame_start = r_fs;

endmodule

// File: tb/tb_lcd_scan.sv
// Bench for lcd_scan with a shortened vertical frame; every pixel and every
// VRAM read is compared against a per-pixel picture model fed by a queue.
module tb_lcd_scan;

   localparam int YS  = 2;
   localparam int VA  = 8;
   localparam int VSS = 9;
   localparam int VSE = 10;
   localparam int VT  = 12;

   logic        mck = 1'b0;
   logic        rin;
   logic        pix_ce;
   logic [13:0] vram_ra;
   logic        vram_re;
   logic [3:0]  vram_di = 4'd0;
   logic        hsync;
   logic        vsync;
   logic        de;
   logic [11:0] rgb;
   logic        frame_start;

   logic [3:0]  vram [16384];

   int          h;
   int          v;
   int          mck_cnt;
   int          last_fs;
   int          exp_period;
   int          pass_cnt;
   int          fail_cnt;
   int          total_cnt;
   logic [15:0] exp_q[$];
   logic [14:0] rd_q[$];
   logic [15:0] last_w;
   logic [14:0] last_rd;

   lcd_scan #(
      .V_ACTIVE    (VA),
      .V_TOTAL     (VT),
      .V_SYNC_START(VSS),
      .V_SYNC_END  (VSE),
      .Y_START     (YS)
   ) dut (
      .mck        (mck),
      .rin        (rin),
      .pix_ce     (pix_ce),
      .vram_ra    (vram_ra),
      .vram_re    (vram_re),
      .vram_di    (vram_di),
      .hsync      (hsync),
      .vsync      (vsync),
      .de         (de),
      .rgb        (rgb),
      .frame_start(frame_start)
   );

   always #5 mck = ~mck;

   always @(posedge mck) if (vram_re) vram_di <= vram[vram_ra];

   function automatic bit in_win(input int vv);
      return (vv >= YS) && (vv < YS + 256);
   endfunction

   // Picture model: {frame_start, hsync, vsync, de, rgb} for the pixel at (hh, vv).
   function automatic logic [15:0] exp_word(input int hh, input int vv);
      logic        de_e;
      logic [11:0] c;
      logic [5:0]  row;
      logic [3:0]  nib;
      de_e = (hh < 640) && (vv < VA);
      c = 12'd0;
      if (de_e) begin
         if (!in_win(vv)) begin
            c = 12'h333;
         end else begin
            row = 6'((vv - YS) >> 2);
            nib = vram[{row, 8'(hh / 4)}];
            c = nib[3 - (hh % 4)] ? 12'h114 : 12'hBCA;
         end
      end
      return {(hh == 0) && (vv == 0), !((hh >= 656) && (hh < 752)),
              !((vv >= VSS) && (vv < VSE)), de_e, c};
   endfunction

   function automatic logic [14:0] exp_rd(input int hh, input int vv);
      int nv;
      nv = (vv == VT - 1) ? 0 : vv + 1;
      if ((hh % 4 == 1) && (hh < 636) && in_win(vv))
         return {1'b1, 6'((vv - YS) >> 2), 8'(hh / 4 + 1)};
      if ((hh == 797) && in_win(nv))
         return {1'b1, 6'((nv - YS) >> 2), 8'd0};
      return 15'd0;
   endfunction

   task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s h=%0d v=%0d observed=%h expected=%h", tag, h, v, obs, exp);
      end
   endtask

   task automatic step(input bit ce);
      logic [15:0] w;
      logic [14:0] r;
      if (ce) begin
         exp_q.push_back(exp_word(h, v));
         rd_q.push_back(exp_rd(h, v));
      end else begin
         exp_q.push_back({1'b0, last_w[14:0]});
         rd_q.push_back(last_rd);
      end
      pix_ce = ce;
      @(posedge mck);
      #1;
      mck_cnt++;
      w = exp_q.pop_front();
      r = rd_q.pop_front();
      last_w  = w;
      last_rd = r;
      check16("pix", {frame_start, hsync, vsync, de, rgb}, w);
      check16("rd", {1'b0, vram_re, vram_re ? vram_ra : 14'd0}, {1'b0, r});
      if (frame_start) begin
         if (last_fs >= 0) check16("fs_period", 16'(mck_cnt - last_fs), 16'(exp_period));
         last_fs = mck_cnt;
      end
      if (ce) begin
         if (h == 799) begin
            h = 0;
            v = (v == VT - 1) ? 0 : v + 1;
         end else begin
            h = h + 1;
         end
      end
   endtask

   initial begin
      pass_cnt   = 0;
      fail_cnt   = 0;
      total_cnt  = 0;
      mck_cnt    = 0;
      last_fs    = -1;
      exp_period = 0;
      h          = 0;
      v          = 0;
      rin        = 1'b1;
      pix_ce     = 1'b0;

      repeat (3) @(posedge mck);
      #1;
      check16("rst", {frame_start, hsync, vsync, de, rgb}, 16'h6000);
      check16("rst_rd", {1'b0, vram_re, vram_ra}, 16'h0000);

      // Row 0 alternating pixels; row 1 only its last pixel set.
      for (int i = 0; i < 16384; i++) vram[i] = 4'd0;
      for (int n = 0; n < 160; n++) vram[{6'd0, 8'(n)}] = 4'hA;
      vram[{6'd1, 8'd159}] = 4'h1;

      rin        = 1'b0;
      last_w     = 16'h6000;
      last_rd    = 15'd0;
      last_fs    = -1;
      exp_period = 9600;
      repeat (19200) step(1'b1);

      // Half-rate pixel enable over one frame with random bitmap content.
      for (int n = 0; n < 160; n++) begin
         vram[{6'd0, 8'(n)}] = 4'($urandom_range(0, 15));
         vram[{6'd1, 8'(n)}] = 4'($urandom_range(0, 15));
         vram[{6'd2, 8'(n)}] = 4'($urandom_range(0, 15));
      end
      last_fs    = -1;
      exp_period = 19200;
      for (int i = 0; i < 9601; i++) begin
         step(1'b1);
         step(1'b0);
      end

      // Full rate up to hcnt=300, vcnt=5, then a one-cycle reset mid-line.
      last_fs    = -1;
      exp_period = 9600;
      for (int i = 0; i < 20000 && !((h == 300) && (v == 5)); i++) step(1'b1);
      rin    = 1'b1;
      pix_ce = 1'b1;
      @(posedge mck);
      #1;
      mck_cnt++;
      check16("rst_mid", {frame_start, hsync, vsync, de, rgb}, 16'h6000);
      check16("rst_mid_rd", {1'b0, vram_re, vram_ra}, 16'h0000);
      rin     = 1'b0;
      h       = 0;
      v       = 0;
      last_w  = 16'h6000;
      last_rd = 15'd0;
      last_fs = -1;
      repeat (1700) step(1'b1);

      pix_ce = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
